datapath_fifo_rd_ctrl: RTL and testbench
========================================

// Module: datapath_fifo_rd_ctrl
// PURPOSE
//  Read-side sequencer for the 192-bit datapath FIFO.
//  - Flushes the FIFO, waits for a preload level, then holds the FIFO read request so the FIFO's paced strobe drains it.
//  - Counts delivered words, ends a frame after frame_len words, and traps underflow.
//  - Sits between the host control registers and the FIFO read port.
// PARAMETERS
//  DEPTH_SIZE     10   log2 of FIFO depth; fifo_data_count is DEPTH_SIZE+1 bits
//  PRELOAD_LEVEL  512  fifo_data_count needed before reads start
//  FLUSH_CYCLES   4    cycles fifo_rstn is held low in FLUSH (>=1)
//  CNT_WIDTH      32   width of frame_len and words_read
// PORTS
//  clk              in   1             system clock
//  rstn             in   1             asynchronous active-low reset
//  start            in   1             1-cycle pulse: begin a frame
//  stop             in   1             1-cycle pulse: abort; stop wins over start in the same cycle
//  frame_len        in   CNT_WIDTH     words per frame, latched on start; 0 = continuous
//  fifo_data_count  in   DEPTH_SIZE+1  FIFO occupancy
//  fifo_rd_valid    in   1             FIFO rd_en_100ns: one word delivered
//  fifo_underflow   in   1             FIFO underflow flag
//  fifo_rstn        out  1             synchronous reset to FIFO, active low
//  fifo_rd          out  1             level read request to FIFO
//  busy             out  1             1 in FLUSH, PRELOAD, RUN
//  done             out  1             1-cycle pulse on frame completion
//  err_underflow    out  1             sticky underflow error
//  words_read       out  CNT_WIDTH     words delivered in current frame
//  state            out  3             FSM state code
// BEHAVIOUR
//  - Reset (async, rstn=0):
//    - state=IDLE, fifo_rstn=1, fifo_rd=0, busy=0, done=0, err_underflow=0, words_read=0.
//    - All outputs are registered.
//  - States: IDLE=0, FLUSH=1, PRELOAD=2, RUN=3, DONE=4, ERROR=5 (6,7 recover to IDLE).
//  - IDLE:
//    - start & !stop -> FLUSH.
//    - Latch len_q=frame_len; clear words_read and err_underflow.
//  - FLUSH:
//    - fifo_rstn=0 for exactly FLUSH_CYCLES cycles, then fifo_rstn=1 and go to PRELOAD.
//    - stop -> IDLE, and fifo_rstn returns to 1 next cycle.
//  - PRELOAD:
//    - fifo_rd=0; target=PRELOAD_LEVEL, or len_q if 0<len_q<PRELOAD_LEVEL.
//    - fifo_data_count>=target -> RUN; fifo_rd rises on the entry cycle.
//    - stop -> IDLE.
//  - RUN:
//    - fifo_rd=1; each fifo_rd_valid: words_read+=1 (wraps mod 2^CNT_WIDTH in continuous mode).
//    - len_q!=0 and fifo_rd_valid with words_read==len_q-1 -> DONE; fifo_rd=0 on the next edge.
//    - FIFO pacing (CLK_DIV>=3) guarantees no extra read.
//    - fifo_underflow=1 -> ERROR; fifo_rd=0, err_underflow=1.
//    - stop -> IDLE with fifo_rd=0 and no done pulse; words_read holds.
//    - Priority: stop > underflow > frame end.
//  - DONE: done=1 for one cycle, then IDLE; words_read holds final count.
//  - ERROR:
//    - fifo_rd=0; err_underflow stays 1.
//    - stop -> IDLE; start -> FLUSH, which clears the error.
//  - start outside IDLE/ERROR is ignored; frame_len changes after start are ignored.
//  - Reset mid-frame: immediate return to reset values; the FIFO is not flushed until the next start.
// TESTING
//  - len=4, PRELOAD=8: start, fill count to 8 -> FLUSH 4 cycles (fifo_rstn=0), RUN, 4 valids -> done 1 cycle, words_read=4, fifo_rd=0.
//  - len=3 (<PRELOAD): count reaches 3 -> RUN entered without waiting for 8.
//  - len=0, 10 valids, then stop -> words_read=10, no done, state=IDLE, fifo_rd=0 next cycle.
//  - RUN with fifo_underflow=1 -> state=5, err_underflow=1, fifo_rd=0; start -> FLUSH, err_underflow=0.
//  - start+stop same cycle in IDLE -> stays IDLE; stop during FLUSH cycle 2 -> IDLE, fifo_rstn=1.
//  - rstn low mid-RUN for 1 cycle -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/datapath_fifo_rd_ctrl.sv
// datapath_fifo_rd_ctrl
// Read-side sequencer for the 192-bit datapath FIFO. A start pulse flushes the
// FIFO, then waits for a preload level. It then holds a level read request so
// that the FIFO's own paced strobe drains it. Delivered words are counted, a
// frame ends after frame_len words, and an underflow is trapped as a sticky
// error. All outputs come straight from flops.
//
// Ports
//   clk              in   system clock
//   rstn             in   asynchronous active-low reset
//   start            in   1-cycle pulse, begin a frame (honoured in IDLE/ERROR)
//   stop             in   1-cycle pulse, abort; beats start in the same cycle
//   frame_len        in   words per frame, latched on start; 0 = continuous
//   fifo_data_count  in   FIFO occupancy
//   fifo_rd_valid    in   one word delivered by the FIFO this cycle
//   fifo_underflow   in   FIFO underflow flag
//   fifo_rstn        out  synchronous active-low reset to the FIFO
//   fifo_rd          out  level read request to the FIFO
//   busy             out  high in FLUSH, PRELOAD, RUN
//   done             out  1-cycle pulse on frame completion
//   err_underflow    out  sticky underflow error, cleared by the next start
//   words_read       out  words delivered in the current frame
//   state            out  FSM state code (IDLE=0 .. ERROR=5)
module datapath_fifo_rd_ctrl #(
  parameter int DEPTH_SIZE    = 10,
  parameter int PRELOAD_LEVEL = 512,
  parameter int FLUSH_CYCLES  = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  frame_len,
  input  logic [DEPTH_SIZE:0]   fifo_data_count,
  input  logic                  fifo_rd_valid,
  input  logic                  fifo_underflow,
  output logic                  fifo_rstn,
  output logic                  fifo_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underflow,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_PRELOAD = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam int                   FC_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]      FLUSH_LAST  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PRELOAD_TGT = CNT_WIDTH'(PRELOAD_LEVEL);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t                state_r;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  len_nxt;
  logic [FC_W-1:0]       flush_cnt;
  logic [FC_W-1:0]       flush_nxt;
  logic [CNT_WIDTH-1:0]  words_nxt;
  logic                  fifo_rstn_nxt;
  logic                  fifo_rd_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  err_nxt;
  logic [CNT_WIDTH-1:0]  preload_target;
  logic                  preload_hit;
  logic                  frame_end;

  assign state = state_r;

  // Preload threshold: short frames only need their own length in the FIFO.
  always_comb begin
    preload_target = PRELOAD_TGT;
    if ((len_q != CNT_ZERO) && (len_q < PRELOAD_TGT)) begin
      preload_target = len_q;
    end else begin
      preload_target = PRELOAD_TGT;
    end
    preload_hit = (CNT_WIDTH'(fifo_data_count) >= preload_target);
    frame_end   = (len_q != CNT_ZERO) && (words_read == (len_q - CNT_ONE));
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt     = state_r;
    len_nxt       = len_q;
    flush_nxt     = flush_cnt;
    words_nxt     = words_read;
    fifo_rstn_nxt = 1'b1;
    fifo_rd_nxt   = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = err_underflow;

    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt     = ST_FLUSH;
          len_nxt       = frame_len;
          words_nxt     = CNT_ZERO;
          err_nxt       = 1'b0;
          flush_nxt     = {FC_W{1'b0}};
          fifo_rstn_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (flush_cnt == FLUSH_LAST) begin
          // FLUSH_CYCLES low cycles done; release the FIFO reset.
          state_nxt = ST_PRELOAD;
        end else begin
          flush_nxt     = flush_cnt + FC_W'(1);
          fifo_rstn_nxt = 1'b0;
        end
      end
      ST_PRELOAD: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (preload_hit) begin
          state_nxt   = ST_RUN;
          fifo_rd_nxt = 1'b1;
        end else begin
          state_nxt = ST_PRELOAD;
        end
      end
      ST_RUN: begin
        // stop beats underflow, underflow beats frame end.
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (fifo_underflow) begin
          state_nxt = ST_ERROR;
          err_nxt   = 1'b1;
        end else if (fifo_rd_valid) begin
          words_nxt = words_read + CNT_ONE;
          if (frame_end) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            fifo_rd_nxt = 1'b1;
          end
        end else begin
          fifo_rd_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          state_nxt     = ST_FLUSH;
          len_nxt       = frame_len;
          words_nxt     = CNT_ZERO;
          err_nxt       = 1'b0;
          flush_nxt     = {FC_W{1'b0}};
          fifo_rstn_nxt = 1'b0;
        end else begin
          state_nxt = ST_ERROR;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == ST_FLUSH) || (state_nxt == ST_PRELOAD) || (state_nxt == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      len_q         <= CNT_ZERO;
      flush_cnt     <= {FC_W{1'b0}};
      words_read    <= CNT_ZERO;
      fifo_rstn     <= 1'b1;
      fifo_rd       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      len_q         <= len_nxt;
      flush_cnt     <= flush_nxt;
      words_read    <= words_nxt;
      fifo_rstn     <= fifo_rstn_nxt;
      fifo_rd       <= fifo_rd_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err_underflow <= err_nxt;
    end
  end

endmodule

// File: tb/tb_datapath_fifo_rd_ctrl.sv
// Self-checking bench for datapath_fifo_rd_ctrl with small parameters so the
// preload short-frame rule and counter wrap are reachable quickly.
module tb_datapath_fifo_rd_ctrl;

  localparam int DS = 10;
  localparam int PL = 8;
  localparam int FC = 4;
  localparam int CW = 8;
  localparam int FW = DS + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          stop;
  logic [CW-1:0] frame_len;
  logic [DS:0]   fifo_data_count;
  logic          fifo_rd_valid;
  logic          fifo_underflow;
  logic          fifo_rstn;
  logic          fifo_rd;
  logic          busy;
  logic          done;
  logic          err_underflow;
  logic [CW-1:0] words_read;
  logic [2:0]    state;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  datapath_fifo_rd_ctrl #(
    .DEPTH_SIZE(DS), .PRELOAD_LEVEL(PL), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .frame_len(frame_len),
    .fifo_data_count(fifo_data_count), .fifo_rd_valid(fifo_rd_valid),
    .fifo_underflow(fifo_underflow), .fifo_rstn(fifo_rstn), .fifo_rd(fifo_rd),
    .busy(busy), .done(done), .err_underflow(err_underflow),
    .words_read(words_read), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  // Reference rule: short frames preload only their own length.
  function automatic int exp_target(input int len);
    return (len != 0 && len < PL) ? len : PL;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One delivered word followed by the FIFO's pacing gap.
  task automatic pulse_valid();
    fifo_rd_valid = 1'b1;
    cyc();
    fifo_rd_valid = 1'b0;
    repeat ($urandom_range(2, 4)) cyc();
  endtask

  task automatic go_run(input int len);
    fifo_data_count = '0;
    frame_len = CW'(len);
    start = 1'b1;
    cyc();
    start = 1'b0;
    frame_len = CW'($urandom);
    for (int i = 0; i < 2 * FC + 2 && state !== 3'd2; i++) cyc();
    fifo_data_count = FW'(exp_target(len));
    for (int i = 0; i < 4 && state !== 3'd3; i++) cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b1; start = 1'b0; stop = 1'b0; frame_len = '0;
    fifo_data_count = '0; fifo_rd_valid = 1'b0; fifo_underflow = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) cyc();
    total++;
    if ({state, fifo_rstn, fifo_rd, busy, done, err_underflow, words_read} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL reset_vals: got st=%0d rstn=%b rd=%b busy=%b done=%b err=%b wr=%0d want 0 1 0 0 0 0 0",
               state, fifo_rstn, fifo_rd, busy, done, err_underflow, words_read);
    end
    rstn = 1'b1;
    repeat (2) cyc();
    total++;
    if ({state, fifo_rstn, busy} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_release: got st=%0d rstn=%b busy=%b want 0 1 0", state, fifo_rstn, busy);
    end
  endtask

  task automatic test_frame(input int iters);
    for (int it = 0; it < iters; it++) begin
      int len;
      int tgt;
      int n;
      int d0;
      len = (it == 0) ? 4 : ((it == 1) ? 3 : int'($urandom_range(1, 20)));
      tgt = exp_target(len);
      d0 = done_seen;
      fifo_data_count = '0;
      frame_len = CW'(len);
      start = 1'b1;
      cyc();
      start = 1'b0;
      frame_len = CW'($urandom);
      total++;
      if ({state, fifo_rstn, busy} !== {3'd1, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL flush_entry: got st=%0d rstn=%b busy=%b want 1 0 1", state, fifo_rstn, busy);
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
        if (fifo_rstn !== 1'b0) break;
        n++;
        cyc();
      end
      total++;
      if (n != FC || state !== 3'd2) begin
        bad++;
        $display("FAIL flush_len: got %0d cycles st=%0d want %0d cycles st=2", n, state, FC);
      end
      fifo_data_count = FW'(tgt - 1);
      repeat (3) cyc();
      total++;
      if (state !== 3'd2 || fifo_rd !== 1'b0) begin
        bad++;
        $display("FAIL preload_hold: len=%0d got st=%0d rd=%b want 2 0", len, state, fifo_rd);
      end
      fifo_data_count = FW'(tgt);
      cyc();
      total++;
      if (state !== 3'd3 || fifo_rd !== 1'b1) begin
        bad++;
        $display("FAIL run_entry: len=%0d got st=%0d rd=%b want 3 1", len, state, fifo_rd);
      end
      for (int k = 1; k < len; k++) begin
        pulse_valid();
        total++;
        if (words_read !== CW'(k) || state !== 3'd3 || fifo_rd !== 1'b1) begin
          bad++;
          $display("FAIL run_count: got wr=%0d st=%0d rd=%b want %0d 3 1", words_read, state, fifo_rd, k);
        end
      end
      fifo_rd_valid = 1'b1;
      cyc();
      fifo_rd_valid = 1'b0;
      total++;
      if ({state, done, fifo_rd, busy} !== {3'd4, 1'b1, 1'b0, 1'b0} || words_read !== CW'(len)) begin
        bad++;
        $display("FAIL frame_done: got st=%0d done=%b rd=%b busy=%b wr=%0d want 4 1 0 0 %0d",
                 state, done, fifo_rd, busy, words_read, len);
      end
      cyc();
      total++;
      if (state !== 3'd0 || done !== 1'b0 || words_read !== CW'(len) || done_seen != d0 + 1) begin
        bad++;
        $display("FAIL frame_idle: got st=%0d done=%b wr=%0d pulses=%0d want 0 0 %0d 1",
                 state, done, words_read, done_seen - d0, len);
      end
    end
  endtask

  task automatic test_continuous(input int nval);
    int d0;
    int expw;
    d0 = done_seen;
    expw = nval % (1 << CW);
    fifo_data_count = '0;
    frame_len = '0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2 * FC + 2 && state !== 3'd2; i++) cyc();
    fifo_data_count = FW'(PL - 1);
    repeat (3) cyc();
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL cont_preload: got st=%0d want 2", state);
    end
    fifo_data_count = FW'(PL);
    cyc();
    total++;
    if (state !== 3'd3 || fifo_rd !== 1'b1) begin
      bad++;
      $display("FAIL cont_run: got st=%0d rd=%b want 3 1", state, fifo_rd);
    end
    for (int i = 0; i < nval; i++) pulse_valid();
    total++;
    if (words_read !== CW'(expw) || state !== 3'd3) begin
      bad++;
      $display("FAIL cont_count: got wr=%0d st=%0d want %0d 3", words_read, state, expw);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++;
    if ({state, fifo_rd, busy, done} !== {3'd0, 1'b0, 1'b0, 1'b0} || words_read !== CW'(expw) || done_seen != d0) begin
      bad++;
      $display("FAIL cont_stop: got st=%0d rd=%b busy=%b wr=%0d pulses=%0d want 0 0 0 %0d 0",
               state, fifo_rd, busy, words_read, done_seen - d0, expw);
    end
  endtask

  task automatic test_underflow();
    int len;
    len = int'($urandom_range(6, 20));
    go_run(len);
    pulse_valid();
    pulse_valid();
    fifo_underflow = 1'b1;
    cyc();
    fifo_underflow = 1'b0;
    total++;
    if ({state, err_underflow, fifo_rd, busy} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL uf_trap: got st=%0d err=%b rd=%b busy=%b want 5 1 0 0", state, err_underflow, fifo_rd, busy);
    end
    repeat (3) cyc();
    total++;
    if (state !== 3'd5 || err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL uf_sticky: got st=%0d err=%b want 5 1", state, err_underflow);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++;
    if ({state, err_underflow, fifo_rstn} !== {3'd1, 1'b0, 1'b0} || words_read !== 8'd0) begin
      bad++;
      $display("FAIL uf_restart: got st=%0d err=%b rstn=%b wr=%0d want 1 0 0 0", state, err_underflow, fifo_rstn, words_read);
    end
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++;
    if (state !== 3'd0 || fifo_rstn !== 1'b1) begin
      bad++;
      $display("FAIL flush_stop: got st=%0d rstn=%b want 0 1", state, fifo_rstn);
    end
    // Final word and underflow together: underflow wins.
    go_run(1);
    fifo_rd_valid = 1'b1;
    fifo_underflow = 1'b1;
    cyc();
    fifo_rd_valid = 1'b0;
    fifo_underflow = 1'b0;
    total++;
    if (state !== 3'd5 || done !== 1'b0 || err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL uf_prio: got st=%0d done=%b err=%b want 5 0 1", state, done, err_underflow);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++;
    if (state !== 3'd0 || err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL uf_stop: got st=%0d err=%b want 0 1", state, err_underflow);
    end
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    total++;
    if ({state, busy, fifo_rstn} !== {3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL start_stop_idle: got st=%0d busy=%b rstn=%b want 0 0 1", state, busy, fifo_rstn);
    end
    fifo_data_count = '0;
    frame_len = 8'd5;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2 * FC + 2 && state !== 3'd2; i++) cyc();
    repeat (2) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL preload_stop: got st=%0d busy=%b want 0 0", state, busy);
    end
    go_run(0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++;
    if (state !== 3'd3 || fifo_rstn !== 1'b1 || fifo_rd !== 1'b1) begin
      bad++;
      $display("FAIL run_start_ignored: got st=%0d rstn=%b rd=%b want 3 1 1", state, fifo_rstn, fifo_rd);
    end
    stop = 1'b1;
    fifo_underflow = 1'b1;
    cyc();
    stop = 1'b0;
    fifo_underflow = 1'b0;
    total++;
    if (state !== 3'd0 || err_underflow !== 1'b0 || fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL stop_prio: got st=%0d err=%b rd=%b want 0 0 0", state, err_underflow, fifo_rd);
    end
  endtask

  task automatic test_async_reset();
    go_run(0);
    repeat (3) pulse_valid();
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    total++;
    if ({state, fifo_rstn, fifo_rd, busy, done, err_underflow, words_read} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL async_reset: got st=%0d rstn=%b rd=%b busy=%b done=%b err=%b wr=%0d want 0 1 0 0 0 0 0",
               state, fifo_rstn, fifo_rd, busy, done, err_underflow, words_read);
    end
    cyc();
    rstn = 1'b1;
    repeat (2) cyc();
    total++;
    if (state !== 3'd0 || fifo_rstn !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_idle: got st=%0d rstn=%b want 0 1", state, fifo_rstn);
    end
  endtask

  initial begin
    test_reset();
    test_frame(6);
    test_continuous(10);
    test_continuous(260);
    test_underflow();
    test_start_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
